// File: rtl/sim_pkg.sv
// Shared defaults and FSM encoding for the data-memory result checker.
package sim_pkg;

  localparam logic [13:0] SimEndAddrDef = 14'h3FFF;
  localparam logic [31:0] SimEndCodeDef = 32'hFFFF_FFFF;
  localparam logic [13:0] TestStartDef  = 14'h2000;
  localparam logic [6:0]  NoErrIdx      = 7'h7F;
  localparam logic [6:0]  ErrCntMax     = 7'h7F;

  typedef enum logic [1:0] {
    StRun,
    StSettle,
    StScan,
    StFin
  } chk_state_e;

endpackage

// File: rtl/dm_result_checker.sv
// Watches the CPU->DM bus for the end-of-program mailbox write, then freezes the CPU and
// compares the DM test region word by word against a golden table.
module dm_result_checker
  import sim_pkg::*;
#(
  parameter logic [13:0] SIM_END_ADDR = SimEndAddrDef,
  parameter logic [31:0] SIM_END_CODE = SimEndCodeDef,
  parameter logic [13:0] TEST_START   = TestStartDef,
  parameter int unsigned MAX_WORDS    = 64,
  parameter int unsigned TIMEOUT      = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dm_web,
  input  logic [13:0] dm_addr,
  input  logic [31:0] dm_di,
  output logic [13:0] chk_addr,
  input  logic [31:0] chk_do,
  output logic        cpu_halt,
  output logic [5:0]  gold_addr,
  input  logic [31:0] gold_data,
  input  logic [6:0]  gold_num,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [6:0]  err_cnt,
  output logic [6:0]  first_err_idx,
  output logic [63:0] cycle_cnt
);

  chk_state_e  r_state;
  logic [6:0]  r_idx;
  logic        r_halt;
  logic        r_done;
  logic        r_timeout;
  logic [6:0]  r_err_cnt;
  logic [6:0]  r_first_err;
  logic [63:0] r_cycle_cnt;

  logic        w_trigger;
  logic [63:0] w_cycle_nxt;
  logic        w_timeout_hit;
  logic [6:0]  w_num;
  logic        w_mismatch;
  logic        w_last;

  // Only a full-word write of the end code to the mailbox ends the program.
  assign w_trigger     = (dm_web == 4'b0000) && (dm_addr == SIM_END_ADDR) &&
                         (dm_di == SIM_END_CODE);
  assign w_cycle_nxt   = r_cycle_cnt + 64'd1;
  assign w_timeout_hit = (w_cycle_nxt == 64'(TIMEOUT));
  assign w_num         = (gold_num > 7'(MAX_WORDS)) ? 7'(MAX_WORDS) : gold_num;
  assign w_mismatch    = (r_idx < w_num) && (chk_do != gold_data);
  assign w_last        = (({1'b0, r_idx} + 8'd1) >= {1'b0, w_num});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_idx       <= 7'd0;
      r_halt      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= 7'd0;
      r_first_err <= NoErrIdx;
      r_cycle_cnt <= 64'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          r_cycle_cnt <= w_cycle_nxt;
          if (w_trigger) begin
            r_state <= StSettle;
            r_halt  <= 1'b1;
          end else if (w_timeout_hit) begin
            // Skip the settle cycle: there is no in-flight trigger write to commit.
            r_state   <= StScan;
            r_halt    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        StSettle: begin
          if (w_num == 7'd0) begin
            r_state <= StFin;
            r_done  <= 1'b1;
          end else begin
            r_state <= StScan;
          end
        end
        StScan: begin
          if (w_mismatch) begin
            if (r_err_cnt != ErrCntMax) r_err_cnt <= r_err_cnt + 7'd1;
            if (r_first_err == NoErrIdx) r_first_err <= r_idx;
          end
          if (w_last) begin
            r_state <= StFin;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
        StFin:   r_state <= StFin;
        default: r_state <= StRun;
      endcase
    end
  end

  // DM is handed to the checker only once the CPU is frozen.
  assign chk_addr      = r_halt ? (TEST_START + {7'b0, r_idx}) : 14'd0;
  assign gold_addr     = r_idx[5:0];
  assign cpu_halt      = r_halt;
  assign done          = r_done;
  assign pass          = r_done && (r_err_cnt == 7'd0) && !r_timeout;
  assign timeout       = r_timeout;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_err;
  assign cycle_cnt     = r_cycle_cnt;

endmodule

// File: tb/tb_dm_result_checker.sv
// Self-checking bench: directed table, randomized runs against a DM/golden model, timeout DUT.
module tb_dm_result_checker;

  localparam logic [13:0] EndAddr = 14'h3FFF;
  localparam logic [31:0] EndCode = 32'hFFFF_FFFF;
  localparam logic [13:0] TStart  = 14'h2000;
  localparam int unsigned ToB     = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  a_web, b_web;
  logic [13:0] a_addr, b_addr, a_chk_addr, b_chk_addr;
  logic [31:0] a_di, b_di, a_chk_do, b_chk_do, a_gold_data, b_gold_data;
  logic        a_halt, b_halt, a_done, b_done, a_pass, b_pass, a_to, b_to;
  logic [5:0]  a_gold_addr, b_gold_addr;
  logic [6:0]  a_gold_num, b_gold_num, a_err, b_err, a_first, b_first;
  logic [63:0] a_cyc, b_cyc;

  logic [31:0] mem_a [16384];
  logic [31:0] mem_b [16384];
  logic [31:0] gold_a [64];
  logic [31:0] gold_b [64];

  assign a_chk_do    = mem_a[a_chk_addr];
  assign b_chk_do    = mem_b[b_chk_addr];
  assign a_gold_data = gold_a[a_gold_addr];
  assign b_gold_data = gold_b[b_gold_addr];

  dm_result_checker u_dut_a (
    .clk(clk), .rst(rst), .dm_web(a_web), .dm_addr(a_addr), .dm_di(a_di),
    .chk_addr(a_chk_addr), .chk_do(a_chk_do), .cpu_halt(a_halt),
    .gold_addr(a_gold_addr), .gold_data(a_gold_data), .gold_num(a_gold_num),
    .done(a_done), .pass(a_pass), .timeout(a_to), .err_cnt(a_err),
    .first_err_idx(a_first), .cycle_cnt(a_cyc)
  );

  dm_result_checker #(.TIMEOUT(ToB)) u_dut_b (
    .clk(clk), .rst(rst), .dm_web(b_web), .dm_addr(b_addr), .dm_di(b_di),
    .chk_addr(b_chk_addr), .chk_do(b_chk_do), .cpu_halt(b_halt),
    .gold_addr(b_gold_addr), .gold_data(b_gold_data), .gold_num(b_gold_num),
    .done(b_done), .pass(b_pass), .timeout(b_to), .err_cnt(b_err),
    .first_err_idx(b_first), .cycle_cnt(b_cyc)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          gnum;
    int          trig_t;
    int          partial_t;
    int          flip_idx;
    logic [31:0] flip;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    a_web = 4'hF;
    b_web = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Byte-lane write into the DM model; active-low lane enables.
  task automatic bus_write_a(input logic [13:0] addr, input logic [31:0] di, input logic [3:0] web);
    logic [31:0] m;
    m = {{8{web[3]}}, {8{web[2]}}, {8{web[1]}}, {8{web[0]}}};
    mem_a[addr] = (mem_a[addr] & m) | (di & ~m);
  endtask

  task automatic load_a(input int gnum);
    for (int i = 0; i < 64; i++) begin
      gold_a[i]         = $urandom;
      mem_a[TStart + i] = gold_a[i];
    end
    a_gold_num = 7'(gnum);
  endtask

  task automatic model_a(input int gnum, output int errs, output int first);
    errs  = 0;
    first = 127;
    for (int i = 0; i < gnum; i++) begin
      if (mem_a[TStart + i] !== gold_a[i]) begin
        if (first == 127) first = i;
        errs++;
      end
    end
    if (errs > 127) errs = 127;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, ".done"},  a_done, 0);
    check({tag, ".pass"},  a_pass, 0);
    check({tag, ".to"},    a_to, 0);
    check({tag, ".err"},   a_err, 0);
    check({tag, ".first"}, a_first, 7'h7F);
    check({tag, ".cyc"},   a_cyc, 0);
    check({tag, ".halt"},  a_halt, 0);
    check({tag, ".chk"},   a_chk_addr, 0);
    check({tag, ".gaddr"}, a_gold_addr, 0);
  endtask

  task automatic run_a(input int trig_t, input int partial_t, input bit rnd_wr, input int gnum,
                       output int halt_e, output int done_e, output bit early_pass);
    logic was_halt;
    halt_e     = -1;
    done_e     = -1;
    early_pass = 1'b0;
    do_reset();
    for (int e = 1; e <= trig_t + gnum + 8; e++) begin
      a_web  = 4'hF;
      a_addr = 14'($urandom);
      a_di   = $urandom;
      if (e == trig_t || e == trig_t + 2) begin
        a_web  = 4'h0;
        a_addr = EndAddr;
        a_di   = EndCode;
      end else if (e == partial_t) begin
        a_web  = 4'b1110;
        a_addr = EndAddr;
        a_di   = EndCode;
      end else if (rnd_wr && e < trig_t && $urandom_range(0, 2) == 0) begin
        a_web  = 4'h0;
        a_addr = TStart + 14'($urandom_range(0, 63));
      end
      was_halt = a_halt;
      @(posedge clk);
      if (!was_halt) bus_write_a(a_addr, a_di, a_web);
      #1;
      if (a_halt && halt_e < 0) halt_e = e;
      if (a_done && done_e < 0) done_e = e;
      if (a_pass && !a_done) early_pass = 1'b1;
      @(negedge clk);
    end
    a_web = 4'hF;
  endtask

  task automatic check_run(input string tag, input int trig_t, input int gnum, input int halt_e,
                           input int done_e, input bit early, input int exp_err,
                           input int exp_first, input bit exp_pass);
    check({tag, ".halt_edge"}, 64'(halt_e), 64'(trig_t));
    check({tag, ".done_edge"}, 64'(done_e), 64'(trig_t + 1 + gnum));
    check({tag, ".err"},       a_err, 64'(exp_err));
    check({tag, ".first"},     a_first, 64'(exp_first));
    check({tag, ".pass"},      a_pass, 64'(exp_pass));
    check({tag, ".to"},        a_to, 0);
    check({tag, ".cyc"},       a_cyc, 64'(trig_t));
    check({tag, ".early_pass"}, 64'(early), 0);
  endtask

  task automatic run_b(input int trig_t, output int halt_e, output int done_e);
    halt_e = -1;
    done_e = -1;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      b_web  = (e == trig_t) ? 4'h0 : 4'hF;
      b_addr = EndAddr;
      b_di   = EndCode;
      @(posedge clk);
      #1;
      if (b_halt && halt_e < 0) halt_e = e;
      if (b_done && done_e < 0) done_e = e;
      @(negedge clk);
    end
    b_web = 4'hF;
  endtask

  initial begin
    int halt_e, done_e, errs, first, gnum, trig;
    bit early;

    tbl[0] = '{4, 100, 0, -1, 32'h0, 0, 127, 1'b1};
    tbl[1] = '{4, 100, 0, 2, 32'h1, 1, 2, 1'b0};
    tbl[2] = '{4, 80, 30, -1, 32'h0, 0, 127, 1'b1};
    tbl[3] = '{0, 40, 0, -1, 32'h0, 0, 127, 1'b1};
    tbl[4] = '{64, 20, 0, 63, 32'h8000_0000, 1, 63, 1'b0};
    tbl[5] = '{4, 60, 0, 5, 32'h1, 0, 127, 1'b1};

    rst        = 1'b1;
    a_web      = 4'hF;
    a_addr     = '0;
    a_di       = '0;
    b_web      = 4'hF;
    b_addr     = '0;
    b_di       = '0;
    a_gold_num = '0;
    b_gold_num = 7'd4;
    for (int i = 0; i < 64; i++) begin
      gold_a[i] = '0;
      gold_b[i] = $urandom;
      mem_b[TStart + i] = gold_b[i];
    end

    repeat (2) @(posedge clk);
    #1;
    check_reset_a("reset");

    foreach (tbl[k]) begin
      load_a(tbl[k].gnum);
      if (tbl[k].flip_idx >= 0) mem_a[TStart + tbl[k].flip_idx] ^= tbl[k].flip;
      run_a(tbl[k].trig_t, tbl[k].partial_t, 1'b0, tbl[k].gnum, halt_e, done_e, early);
      check_run($sformatf("tbl%0d", k), tbl[k].trig_t, tbl[k].gnum, halt_e, done_e, early,
                tbl[k].exp_err, tbl[k].exp_first, tbl[k].exp_pass);
    end

    for (int r = 0; r < 8; r++) begin
      gnum = $urandom_range(0, 64);
      trig = $urandom_range(3, 150);
      load_a(gnum);
      for (int f = 0; f < 3; f++) mem_a[TStart + $urandom_range(0, 63)] ^= $urandom;
      run_a(trig, 0, 1'b1, gnum, halt_e, done_e, early);
      model_a(gnum, errs, first);
      check_run($sformatf("rnd%0d", r), trig, gnum, halt_e, done_e, early, errs, first,
                errs == 0);
    end

    // Reset in the middle of a scan with errors already accumulated.
    load_a(64);
    mem_a[TStart] ^= 32'h1;
    mem_a[TStart + 1] ^= 32'h2;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      a_web  = (e == 10) ? 4'h0 : 4'hF;
      a_addr = EndAddr;
      a_di   = EndCode;
      @(negedge clk);
    end
    check("midscan.halt_before", a_halt, 1);
    check("midscan.err_before", a_err, 2);
    a_web = 4'hF;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check_reset_a("midscan");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midscan.run_cyc", a_cyc, 1);
    check("midscan.run_halt", a_halt, 0);

    run_b(0, halt_e, done_e);
    check("to.halt_edge", 64'(halt_e), 64'(ToB));
    check("to.done_edge", 64'(done_e), 64'(ToB + 4));
    check("to.timeout", b_to, 1);
    check("to.pass", b_pass, 0);
    check("to.err", b_err, 0);
    check("to.cyc", b_cyc, 64'(ToB));

    run_b(ToB, halt_e, done_e);
    check("tie.halt_edge", 64'(halt_e), 64'(ToB));
    check("tie.done_edge", 64'(done_e), 64'(ToB + 5));
    check("tie.timeout", b_to, 0);
    check("tie.pass", b_pass, 1);
    check("tie.cyc", b_cyc, 64'(ToB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_result_checker.md
DM_RESULT_CHECKER -- requirements
Module: dm_result_checker

Interface
REQ-001 SHALL have parameter SIM_END_ADDR, default 14'h3FFF, DM word index of the end-of-program mailbox.
REQ-002 SHALL have parameter SIM_END_CODE, default 32'hFFFF_FFFF, mailbox value that signals program end.
REQ-003 SHALL have parameter TEST_START, default 14'h2000, first DM word index compared.
REQ-004 SHALL have parameter MAX_WORDS, default 64, golden table depth.
REQ-005 SHALL have parameter TIMEOUT, default 500000, cycles from reset release to forced finish.
REQ-006 SHALL have ports: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-007 SHALL have ports: dm_web in 4 DM byte write enables (active-low); dm_addr in 14 DM word index; dm_di in 32 DM write data. All three are snooped from the CPU to DM bus.
REQ-008 SHALL have ports: chk_addr out 14 checker DM read index; chk_do in 32 DM read data, same-cycle (no-delay SRAM); cpu_halt out 1, high means the CPU is frozen and DM is muxed to chk_addr.
REQ-009 SHALL have ports: gold_addr out 6 golden index; gold_data in 32 golden word, same-cycle; gold_num in 7 valid golden count (0..MAX_WORDS).
REQ-010 SHALL have ports: done out 1; pass out 1; timeout out 1; err_cnt out 7; first_err_idx out 7; cycle_cnt out 64.

Function
REQ-011 SHALL implement FSM RUN -> SETTLE -> SCAN -> FIN, where FIN is terminal until rst.
REQ-012 SHALL leave RUN when dm_web==4'b0000, dm_addr==SIM_END_ADDR and dm_di==SIM_END_CODE in the same cycle; partial-byte writes to the mailbox never trigger.
REQ-013 SHALL spend exactly one cycle in SETTLE so the trigger write commits; cpu_halt rises on entry to SETTLE and stays high until rst.
REQ-014 SHALL, in SCAN, compare chk_do against gold_data for index i = 0..gold_num-1, one word per cycle, with chk_addr = TEST_START+i and gold_addr = i.
REQ-015 SHALL compare all 32 bits exactly and count any mismatch; err_cnt saturates at 127.
REQ-016 SHALL record the first mismatching i in first_err_idx; it reads 7'h7F when no mismatch occurs.
REQ-017 SHALL go from SETTLE directly to FIN when gold_num==0, giving pass=1.
REQ-018 SHALL have SCAN occupy exactly gold_num cycles; done rises the cycle after the last compare.
REQ-019 SHALL increment cycle_cnt every cycle in RUN and freeze it on leaving RUN (mailbox write cycle counted).
REQ-020 SHALL, if cycle_cnt reaches TIMEOUT in RUN, go to SCAN (no SETTLE) with timeout=1; pass is then forced 0 regardless of compares.
REQ-021 SHALL, if the trigger and timeout occur in the same cycle, take the trigger path with timeout=0.
REQ-022 SHALL set pass = (err_cnt==0) && !timeout, valid only while done=1; pass=0 while done=0.
REQ-023 SHALL ignore further mailbox writes after RUN.

Reset
REQ-024 SHALL, while rst is high at a clk edge, enter RUN and clear done, pass, timeout, err_cnt, cycle_cnt, cpu_halt and chk_addr/gold_addr (0); first_err_idx=7'h7F.
REQ-025 SHALL let reset asserted mid-SCAN abandon the scan with no output retaining a prior value.

Structure
REQ-026 SHALL place SIM_END_ADDR/SIM_END_CODE/TEST_START defaults and the FSM state enum in shared package sim_pkg.
REQ-027 SHALL be a single module with no sub-modules; DM address muxing on cpu_halt belongs in top.

Verification
REQ-028 SHALL cover: 4 golden words all matching, mailbox write at cycle 100 -> cpu_halt at 101, done at 106, pass=1, err_cnt=0, cycle_cnt=100.
REQ-029 SHALL cover: golden[2] differs in bit 0 -> err_cnt=1, first_err_idx=2, pass=0.
REQ-030 SHALL cover: mailbox write with dm_web=4'b1110 -> no trigger; full write later -> trigger.
REQ-031 SHALL cover: TIMEOUT=50, no mailbox write -> timeout=1, scan runs, pass=0, cycle_cnt=50.
REQ-032 SHALL cover: gold_num=0 -> done two cycles after trigger, pass=1.
REQ-033 SHALL cover: rst asserted mid-SCAN -> next cycle RUN, all outputs at reset values, cpu_halt=0.
